// File: rtl/npu_ucode_pkg.sv
// npu_ucode_pkg: shared microcode definitions for the NPU instruction path.
// Used by the host-side loader (ucode_loader) and by the controller decode.
// Holds the 128-bit instruction layout, the opcode values, the opcode
// legality helper and the loader FSM state type.
package npu_ucode_pkg;

   // One microcode instruction, little-endian over four 32-bit host beats:
   // opcode/flags land in beat 0, imm lands in the top half of beat 3.
   typedef struct packed {
      logic [15:0] imm;
      logic [15:0] k;
      logic [15:0] n;
      logic [15:0] m;
      logic [15:0] src1;
      logic [15:0] src0;
      logic [15:0] dst;
      logic [7:0]  flags;
      logic [7:0]  opcode;
   } instruction_t;

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_DMA_LOAD  = 8'h01;
   localparam logic [7:0] OP_DMA_STORE = 8'h02;
   localparam logic [7:0] OP_GEMM      = 8'h03;
   localparam logic [7:0] OP_VEC       = 8'h04;
   localparam logic [7:0] OP_SOFTMAX   = 8'h05;
   localparam logic [7:0] OP_LAYERNORM = 8'h06;
   localparam logic [7:0] OP_GELU      = 8'h07;
   localparam logic [7:0] OP_BARRIER   = 8'hFE;
   localparam logic [7:0] OP_END       = 8'hFF;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RECV   = 3'd1,
      ST_WRITE  = 3'd2,
      ST_FINISH = 3'd3,
      ST_ERR    = 3'd4
   } load_state_e;

   // True when the opcode belongs to the architected set.
   function automatic logic op_legal(input logic [7:0] op);
      logic ok;
      case (op)
         OP_NOP, OP_DMA_LOAD, OP_DMA_STORE, OP_GEMM, OP_VEC,
         OP_SOFTMAX, OP_LAYERNORM, OP_GELU, OP_BARRIER, OP_END: ok = 1'b1;
         default:                                              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ucode_word_packer.sv
// ucode_word_packer: assembles four 32-bit beats into one 128-bit word.
// clear_i restarts at beat 0; load_i accepts data_i into the current slot.
// word_o is the word including the beat being loaded this cycle, so the
// full instruction is available in the same cycle full_o reports beat 3.
module ucode_word_packer (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic [31:0]  data_i,
   output logic         full_o,
   output logic [127:0] word_o
);

   logic [1:0]   beat_q;
   logic [1:0]   beat_d;
   logic [127:0] word_q;
   logic [127:0] word_d;

   // Merge the incoming beat into its little-endian slot and advance the beat.
   always_comb begin
      word_d = word_q;
      beat_d = beat_q;
      if (load_i) begin
         case (beat_q)
            2'd0:    word_d[31:0]   = data_i;
            2'd1:    word_d[63:32]  = data_i;
            2'd2:    word_d[95:64]  = data_i;
            2'd3:    word_d[127:96] = data_i;
            default: word_d         = word_q;
         endcase
         beat_d = beat_q + 2'd1;
      end else begin
         beat_d = beat_q;
      end
   end

   // Beat counter and assembly register; clear wins over load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= 2'd0;
         word_q <= 128'd0;
      end else if (clear_i) begin
         beat_q <= 2'd0;
         word_q <= 128'd0;
      end else begin
         beat_q <= beat_d;
         word_q <= word_d;
      end
   end

   assign full_o = load_i && (beat_q == 2'd3);
   assign word_o = word_d;

endmodule

// File: rtl/ucode_loader.sv
// ucode_loader: host-side microcode SRAM writer. Packs 32-bit host words
// into 128-bit instructions and writes them to base, base+1, ... (address
// wraps modulo 2^ADDR_WIDTH). Reports length/base on success and can pulse
// the controller start. All outputs are registered.
// Build option: UCODE_LOADER_OPCHECK_EN enables opcode legality checking and
// requires the final instruction to be OP_END.
module ucode_loader
   import npu_ucode_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_INSTRS = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH-1:0] load_base_addr,
   input  logic                  auto_start,
   input  logic                  host_wr_valid,
   output logic                  host_wr_ready,
   input  logic [31:0]           host_wr_data,
   input  logic                  host_wr_last,
   output logic                  sram_wr_en,
   output logic [ADDR_WIDTH-1:0] sram_wr_addr,
   output logic [127:0]          sram_wr_data,
   input  logic                  ctrl_busy,
   output logic                  ctrl_start,
   output logic [ADDR_WIDTH-1:0] ucode_base_addr,
   output logic [15:0]           ucode_length,
   output logic                  loading,
   output logic                  load_done,
   output logic                  load_error
);

   localparam logic [15:0] MAX_COUNT = 16'(MAX_INSTRS);

   load_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [15:0]           count_q, count_d;
   logic                  last_q, last_d;
   logic                  end_ok_q, end_ok_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   instruction_t          wr_data_q, wr_data_d;
   logic                  ready_q;
   logic                  loading_q;
   logic                  done_q;
   logic                  start_q;
   logic                  error_q;
   logic [15:0]           length_q;
   logic [ADDR_WIDTH-1:0] ubase_q;

   logic                  accept_s;
   logic                  pk_clear_s;
   logic                  pk_load_s;
   logic                  pk_full_s;
   logic [127:0]          pk_word_s;
   instruction_t          pk_instr_s;
   logic                  op_ok_s;
   logic                  end_ok_s;

   ucode_word_packer u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (pk_clear_s),
      .load_i  (pk_load_s),
      .data_i  (host_wr_data),
      .full_o  (pk_full_s),
      .word_o  (pk_word_s)
   );

   assign pk_instr_s = pk_word_s;
   assign accept_s   = host_wr_valid && ready_q;

`ifdef UCODE_LOADER_OPCHECK_EN
   assign op_ok_s  = op_legal(pk_instr_s.opcode);
   assign end_ok_s = (pk_instr_s.opcode == OP_END);
`else
   assign op_ok_s  = 1'b1;
   assign end_ok_s = 1'b1;
`endif

   // Next-state, counters and the pending SRAM write.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      last_d     = last_q;
      end_ok_d   = end_ok_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      pk_clear_s = 1'b0;
      pk_load_s  = 1'b0;
      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (load_start) begin
               if (ctrl_busy) begin
                  state_d = ST_ERR;
               end else begin
                  state_d    = ST_RECV;
                  base_d     = load_base_addr;
                  count_d    = 16'd0;
                  pk_clear_s = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_RECV: begin
            if (accept_s) begin
               pk_load_s = 1'b1;
               if (pk_full_s) begin
                  state_d   = ST_WRITE;
                  last_d    = host_wr_last;
                  end_ok_d  = end_ok_s;
                  // Full program or illegal opcode: WRITE cycle without a strobe, then ERR.
                  wr_en_d   = (count_q != MAX_COUNT) && op_ok_s;
                  wr_addr_d = base_q + ADDR_WIDTH'(count_q);
                  wr_data_d = pk_instr_s;
               end else if (host_wr_last) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_RECV;
               end
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_WRITE: begin
            if (wr_en_q) begin
               count_d = count_q + 16'd1;
               if (last_q) begin
                  state_d = end_ok_q ? ST_FINISH : ST_ERR;
               end else begin
                  state_d = ST_RECV;
               end
            end else begin
               state_d = ST_ERR;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         count_q   <= 16'd0;
         last_q    <= 1'b0;
         end_ok_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ready_q   <= 1'b0;
         loading_q <= 1'b0;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
         error_q   <= 1'b0;
         length_q  <= 16'd0;
         ubase_q   <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         count_q   <= count_d;
         last_q    <= last_d;
         end_ok_q  <= end_ok_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ready_q   <= (state_d == ST_RECV);
         loading_q <= (state_d == ST_RECV) || (state_d == ST_WRITE) ||
                      (state_d == ST_FINISH);
         done_q    <= (state_d == ST_FINISH);
         start_q   <= (state_d == ST_FINISH) && auto_start && !ctrl_busy;
         error_q   <= (state_d == ST_ERR);
         // Publish the result together with the load_done pulse.
         if (state_d == ST_FINISH) begin
            length_q <= count_d;
            ubase_q  <= base_q;
         end
      end
   end

   assign host_wr_ready   = ready_q;
   assign sram_wr_en      = wr_en_q;
   assign sram_wr_addr    = wr_addr_q;
   assign sram_wr_data    = wr_data_q;
   assign ctrl_start      = start_q;
   assign ucode_base_addr = ubase_q;
   assign ucode_length    = length_q;
   assign loading         = loading_q;
   assign load_done       = done_q;
   assign load_error      = error_q;

endmodule

// File: tb/tb_ucode_loader.sv
// tb_ucode_loader: directed, scoreboard-based bench for ucode_loader.
// Expected SRAM writes are queued when a program is sent and compared as the
// DUT strobes sram_wr_en. The DUT runs with MAX_INSTRS=4 so overflow is cheap.
module tb_ucode_loader;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start;
   logic [AW-1:0] load_base_addr;
   logic          auto_start;
   logic          host_wr_valid;
   logic          host_wr_ready;
   logic [31:0]   host_wr_data;
   logic          host_wr_last;
   logic          sram_wr_en;
   logic [AW-1:0] sram_wr_addr;
   logic [127:0]  sram_wr_data;
   logic          ctrl_busy;
   logic          ctrl_start;
   logic [AW-1:0] ucode_base_addr;
   logic [15:0]   ucode_length;
   logic          loading;
   logic          load_done;
   logic          load_error;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [127:0]  data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  total = 0;
   int  bad   = 0;

   // Instruction I0: GEMM, flags 0x01, imm 0x1234. I1: END. IX: illegal 0x09.
   localparam logic [31:0] I0W0 = 32'hA5A5_0103;
   localparam logic [31:0] I0W1 = 32'h0011_0022;
   localparam logic [31:0] I0W2 = 32'h0033_0044;
   localparam logic [31:0] I0W3 = 32'h1234_0055;
   localparam logic [31:0] I1W0 = 32'h0000_00FF;
   localparam logic [31:0] I1W1 = 32'hDEAD_BEEF;
   localparam logic [31:0] I1W2 = 32'hCAFE_F00D;
   localparam logic [31:0] I1W3 = 32'h5678_9ABC;
   localparam logic [31:0] IXW0 = 32'h0000_0009;

   always #5 clk = ~clk;

   ucode_loader #(.ADDR_WIDTH(AW), .MAX_INSTRS(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .load_start      (load_start),
      .load_base_addr  (load_base_addr),
      .auto_start      (auto_start),
      .host_wr_valid   (host_wr_valid),
      .host_wr_ready   (host_wr_ready),
      .host_wr_data    (host_wr_data),
      .host_wr_last    (host_wr_last),
      .sram_wr_en      (sram_wr_en),
      .sram_wr_addr    (sram_wr_addr),
      .sram_wr_data    (sram_wr_data),
      .ctrl_busy       (ctrl_busy),
      .ctrl_start      (ctrl_start),
      .ucode_base_addr (ucode_base_addr),
      .ucode_length    (ucode_length),
      .loading         (loading),
      .load_done       (load_done),
      .load_error      (load_error)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
      wr_t e;
      e.addr = a;
      e.data = {w3, w2, w1, w0};
      exp_q.push_back(e);
   endtask

   task automatic start_load(input logic [AW-1:0] base);
      load_base_addr = base;
      load_start     = 1'b1;
      tick();
      load_start     = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last, input bit gap);
      int n;
      host_wr_valid = 1'b1;
      host_wr_data  = d;
      host_wr_last  = last;
      n = 0;
      @(negedge clk);
      while (host_wr_ready !== 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) chk("ready_timeout", 128'(host_wr_ready), 128'd1);
      @(posedge clk);
      #1;
      host_wr_valid = 1'b0;
      host_wr_last  = 1'b0;
      if (gap) tick();
   endtask

   task automatic send_instr(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                             input logic [31:0] w3, input logic last, input bit gap);
      send_word(w0, 1'b0, gap);
      send_word(w1, 1'b0, gap);
      send_word(w2, 1'b0, gap);
      send_word(w3, last, gap);
   endtask

   task automatic wait_end(output bit done, output bit err, output bit start_at_done, output bit start_any);
      done = 1'b0; err = 1'b0; start_at_done = 1'b0; start_any = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (ctrl_start === 1'b1) start_any = 1'b1;
         if (load_done === 1'b1) begin
            done = 1'b1;
            start_at_done = (ctrl_start === 1'b1);
            break;
         end
         if (load_error === 1'b1) begin
            err = 1'b1;
            break;
         end
      end
      tick();
   endtask

   // Scoreboard: every SRAM strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && sram_wr_en === 1'b1) begin
         chk("wr_expected", 128'(exp_q.size() > 0), 128'd1);
         chk("ready_low_in_write", 128'(host_wr_ready), 128'd0);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 128'(sram_wr_addr), 128'(mon_e.addr));
            chk("wr_data", sram_wr_data, mon_e.data);
         end
      end
   end

   // Run-time bound.
   initial begin
      #500000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit done, err, sad, sany;
      rst_n = 1'b0; load_start = 1'b0; load_base_addr = '0; auto_start = 1'b0;
      host_wr_valid = 1'b0; host_wr_data = 32'd0; host_wr_last = 1'b0; ctrl_busy = 1'b0;

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_flags", 128'({host_wr_ready, sram_wr_en, ctrl_start, loading, load_done, load_error}), 128'd0);
      chk("reset_length", 128'(ucode_length), 128'd0);
      chk("reset_base", 128'(ucode_base_addr), 128'd0);
      chk("reset_wr", {112'(sram_wr_addr), 16'd0} | sram_wr_data, 128'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Two-instruction load with auto start.
      auto_start = 1'b1;
      start_load(16'h0040);
      chk("ready_after_start", 128'(host_wr_ready), 128'd1);
      chk("loading_after_start", 128'(loading), 128'd1);
      push_exp(16'h0040, I0W0, I0W1, I0W2, I0W3);
      push_exp(16'h0041, I1W0, I1W1, I1W2, I1W3);
      send_instr(I0W0, I0W1, I0W2, I0W3, 1'b0, 1'b0);
      send_instr(I1W0, I1W1, I1W2, I1W3, 1'b1, 1'b0);
      wait_end(done, err, sad, sany);
      chk("a_done", 128'(done), 128'd1);
      chk("a_err", 128'(err), 128'd0);
      chk("a_start_with_done", 128'(sad), 128'd1);
      chk("a_done_pulse", 128'({load_done, ctrl_start}), 128'd0);
      chk("a_length", 128'(ucode_length), 128'd2);
      chk("a_base", 128'(ucode_base_addr), 128'h40);
      chk("a_loading_idle", 128'(loading), 128'd0);
      chk("a_writes", 128'(exp_q.size()), 128'd0);

      // Backpressure, no auto start.
      auto_start = 1'b0;
      start_load(16'h0100);
      push_exp(16'h0100, I0W0, I0W1, I0W2, I0W3);
      push_exp(16'h0101, I1W0, I1W1, I1W2, I1W3);
      send_instr(I0W0, I0W1, I0W2, I0W3, 1'b0, 1'b1);
      send_instr(I1W0, I1W1, I1W2, I1W3, 1'b1, 1'b1);
      wait_end(done, err, sad, sany);
      chk("b_done", 128'(done), 128'd1);
      chk("b_no_start", 128'(sany), 128'd0);
      chk("b_length", 128'(ucode_length), 128'd2);
      chk("b_base", 128'(ucode_base_addr), 128'h100);
      chk("b_writes", 128'(exp_q.size()), 128'd0);

      // Partial instruction: last on beat 2.
      start_load(16'h0200);
      send_word(I0W0, 1'b0, 1'b0);
      send_word(I0W1, 1'b0, 1'b0);
      send_word(I0W2, 1'b1, 1'b0);
      wait_end(done, err, sad, sany);
      chk("c_err", 128'(err), 128'd1);
      chk("c_done", 128'(done), 128'd0);
      chk("c_error_sticky", 128'(load_error), 128'd1);
      chk("c_ready", 128'(host_wr_ready), 128'd0);
      chk("c_length", 128'(ucode_length), 128'd2);
      chk("c_base", 128'(ucode_base_addr), 128'h100);

      // Start while the controller is busy, then a clean retry.
      ctrl_busy = 1'b1;
      auto_start = 1'b1;
      start_load(16'h0300);
      tick();
      chk("d_busy_err", 128'(load_error), 128'd1);
      chk("d_busy_ready", 128'({host_wr_ready, loading}), 128'd0);
      ctrl_busy = 1'b0;
      start_load(16'h0300);
      chk("d_err_cleared", 128'(load_error), 128'd0);
      chk("d_ready", 128'(host_wr_ready), 128'd1);
      ctrl_busy = 1'b1;
      push_exp(16'h0300, I1W0, I1W1, I1W2, I1W3);
      send_instr(I1W0, I1W1, I1W2, I1W3, 1'b1, 1'b0);
      wait_end(done, err, sad, sany);
      chk("d_done", 128'(done), 128'd1);
      chk("d_start_suppressed", 128'(sany), 128'd0);
      chk("d_length", 128'(ucode_length), 128'd1);
      chk("d_base", 128'(ucode_base_addr), 128'h300);
      chk("d_writes", 128'(exp_q.size()), 128'd0);
      ctrl_busy = 1'b0;

      // Overflow past MAX_INSTRS=4, with the address wrapping past 0xFFFF.
      start_load(16'hFFFE);
      push_exp(16'hFFFE, I0W0, I0W1, I0W2, I0W3);
      push_exp(16'hFFFF, I0W0, I0W1, I0W2, I0W3);
      push_exp(16'h0000, I0W0, I0W1, I0W2, I0W3);
      push_exp(16'h0001, I0W0, I0W1, I0W2, I0W3);
      for (int i = 0; i < 4; i++) send_instr(I0W0, I0W1, I0W2, I0W3, 1'b0, 1'b0);
      send_instr(I1W0, I1W1, I1W2, I1W3, 1'b1, 1'b0);
      wait_end(done, err, sad, sany);
      chk("e_err", 128'(err), 128'd1);
      chk("e_no_done", 128'(done), 128'd0);
      chk("e_length", 128'(ucode_length), 128'd1);
      chk("e_base", 128'(ucode_base_addr), 128'h300);
      chk("e_writes", 128'(exp_q.size()), 128'd0);

      // Opcode 0x09 as a one-instruction program.
      start_load(16'h0010);
`ifdef UCODE_LOADER_OPCHECK_EN
      send_instr(IXW0, I0W1, I0W2, I0W3, 1'b1, 1'b0);
      wait_end(done, err, sad, sany);
      chk("f_err", 128'(err), 128'd1);
      chk("f_length", 128'(ucode_length), 128'd1);
`else
      push_exp(16'h0010, IXW0, I0W1, I0W2, I0W3);
      send_instr(IXW0, I0W1, I0W2, I0W3, 1'b1, 1'b0);
      wait_end(done, err, sad, sany);
      chk("f_done", 128'(done), 128'd1);
      chk("f_length", 128'(ucode_length), 128'd1);
      chk("f_base", 128'(ucode_base_addr), 128'h10);
`endif
      repeat (3) tick();
      chk("f_writes", 128'(exp_q.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
